// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and sizing for the I/D cache memory arbiter
package mem_arb_pkg;
    localparam int ADDR_W          = 16;
    localparam int DATA_W          = 16;
    localparam int MEM_LAT         = 4;
    localparam int MAX_OUTSTANDING = 4;
    localparam int CNT_W           = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache request, memory and cache return signals of the arbiter
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              icache_MemRead;
    logic [ADDR_W-1:0] icache_mem_addr;
    logic              dcache_MemRead;
    logic              dcache_MemWrite;
    logic [ADDR_W-1:0] dcache_mem_addr;
    logic [DATA_W-1:0] dcache_mem_write_data;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_data_valid;

    logic              mem_enable;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              icache_MemDataValid;
    logic [DATA_W-1:0] icache_mem_read_data;
    logic              dcache_MemDataValid;
    logic [DATA_W-1:0] dcache_mem_read_data;
    logic              icache_grant;
    logic              dcache_grant;

    modport slave (
        input  icache_MemRead, icache_mem_addr,
        input  dcache_MemRead, dcache_MemWrite, dcache_mem_addr, dcache_mem_write_data,
        input  mem_data_out, mem_data_valid,
        output mem_enable, mem_wr, mem_addr, mem_data_in,
        output icache_MemDataValid, icache_mem_read_data,
        output dcache_MemDataValid, dcache_mem_read_data,
        output icache_grant, dcache_grant
    );

    modport master (
        output icache_MemRead, icache_mem_addr,
        output dcache_MemRead, dcache_MemWrite, dcache_mem_addr, dcache_mem_write_data,
        output mem_data_out, mem_data_valid,
        input  mem_enable, mem_wr, mem_addr, mem_data_in,
        input  icache_MemDataValid, icache_mem_read_data,
        input  dcache_MemDataValid, dcache_mem_read_data,
        input  icache_grant, dcache_grant
    );
endinterface

// File: rtl/mem_outstanding_ctr.sv
// rtl/mem_outstanding_ctr.sv - saturating count of reads issued but not yet returned
module mem_outstanding_ctr
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_next_o,
    output logic             full_o
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Issue and return in the same cycle cancel out; clamps guard both ends.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && count_q != CNT_W'(MAX_OUTSTANDING)) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec_i && !inc_i && count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign full_o       = (count_q == CNT_W'(MAX_OUTSTANDING));
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between I-cache and D-cache
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    mem_arbiter_if.slave        bus
);
    arb_state_e       state_q;
    owner_e           last_owner_q;
    logic             i_req;
    logic             d_req;
    logic             owner_req;
    logic             owner_wr;
    logic             valid_ok;
    logic             stall;
    logic             issue_rd;
    logic             ctr_full;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;

    assign i_req = bus.icache_MemRead;
    assign d_req = bus.dcache_MemRead | bus.dcache_MemWrite;

    always_comb begin
        owner_req = 1'b0;
        owner_wr  = 1'b0;
        case (state_q)
            GRANT_I: owner_req = i_req;
            GRANT_D: begin
                owner_req = d_req;
                owner_wr  = bus.dcache_MemWrite;
            end
            default: ;
        endcase
    end

    // Returns with nothing outstanding (stale or post-reset) are discarded.
    assign valid_ok = bus.mem_data_valid && (state_q != IDLE) && (outstanding != '0);

    // A return in the same cycle frees a slot, so a full counter need not stall then.
    assign stall    = ctr_full && !owner_wr && !valid_ok;
    assign issue_rd = bus.mem_enable && !bus.mem_wr;

    assign bus.mem_enable  = owner_req && !stall;
    assign bus.mem_wr      = bus.mem_enable && owner_wr;
    assign bus.mem_addr    = (state_q == GRANT_I) ? bus.icache_mem_addr :
                             (state_q == GRANT_D) ? bus.dcache_mem_addr : '0;
    assign bus.mem_data_in = (state_q == GRANT_D) ? bus.dcache_mem_write_data : '0;

    assign bus.icache_grant         = (state_q == GRANT_I);
    assign bus.dcache_grant         = (state_q == GRANT_D);
    assign bus.icache_MemDataValid  = valid_ok && (state_q == GRANT_I);
    assign bus.dcache_MemDataValid  = valid_ok && (state_q == GRANT_D);
    assign bus.icache_mem_read_data = bus.icache_MemDataValid ? bus.mem_data_out : '0;
    assign bus.dcache_mem_read_data = bus.dcache_MemDataValid ? bus.mem_data_out : '0;

    mem_outstanding_ctr u_ctr (
        .clk          (clk),
        .rst          (rst),
        .inc_i        (issue_rd),
        .dec_i        (valid_ok),
        .count_o      (outstanding),
        .count_next_o (outstanding_next),
        .full_o       (ctr_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_I;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req && d_req) begin
                        state_q <= (last_owner_q == OWNER_I) ? GRANT_D : GRANT_I;
                    end else if (d_req) begin
                        state_q <= GRANT_D;
                    end else if (i_req) begin
                        state_q <= GRANT_I;
                    end
                end
                GRANT_I: begin
                    if (!owner_req && outstanding_next == '0) begin
                        state_q      <= IDLE;
                        last_owner_q <= OWNER_I;
                    end
                end
                GRANT_D: begin
                    if (!owner_req && outstanding_next == '0) begin
                        state_q      <= IDLE;
                        last_owner_q <= OWNER_D;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: fixed latency, returns an incrementing sequence starting at 1.
    logic               model_on;
    logic [MEM_LAT-1:0] pipe_v;
    logic [15:0]        pipe_d [MEM_LAT];
    logic [15:0]        seq;
    logic               man_valid;
    logic [15:0]        man_data;

    always @(posedge clk) begin
        if (rst) begin
            pipe_v <= '0;
            seq    <= 16'd1;
        end else begin
            for (int i = MEM_LAT - 1; i > 0; i--) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
            pipe_v[0] <= model_on && bus.mem_enable && !bus.mem_wr;
            pipe_d[0] <= seq;
            if (model_on && bus.mem_enable && !bus.mem_wr) seq <= seq + 16'd1;
        end
    end

    assign bus.mem_data_valid = model_on ? pipe_v[MEM_LAT-1] : man_valid;
    assign bus.mem_data_out   = model_on ? pipe_d[MEM_LAT-1] : man_data;

    task automatic do_reset();
        rst = 1'b1;
        model_on = 1'b0;
        man_valid = 1'b0;
        man_data = 16'h0;
        bus.icache_MemRead = 1'b0;
        bus.icache_mem_addr = 16'h0;
        bus.dcache_MemRead = 1'b0;
        bus.dcache_MemWrite = 1'b0;
        bus.dcache_mem_addr = 16'h0;
        bus.dcache_mem_write_data = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.icache_grant !== 1'b0) begin errors++; $display("FAIL reset_igrant got %b exp 0", bus.icache_grant); end
        checks++; if (bus.dcache_grant !== 1'b0) begin errors++; $display("FAIL reset_dgrant got %b exp 0", bus.dcache_grant); end
        checks++; if (bus.mem_enable !== 1'b0) begin errors++; $display("FAIL reset_mem_enable got %b exp 0", bus.mem_enable); end
        checks++; if (bus.mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0000", bus.mem_addr); end
        checks++; if (dut.outstanding !== 3'd0) begin errors++; $display("FAIL reset_ctr got %0d exp 0", dut.outstanding); end
    endtask

    task automatic test_i_fill();
        int  issued;
        int  got;
        bit  done;
        do_reset();
        model_on = 1'b1;
        bus.icache_MemRead = 1'b1;
        bus.icache_mem_addr = 16'h0;
        #1;
        checks++; if (bus.icache_grant !== 1'b0) begin errors++; $display("FAIL fill_grant_latency got %b exp 0", bus.icache_grant); end
        @(negedge clk); #1;
        checks++; if (bus.icache_grant !== 1'b1) begin errors++; $display("FAIL fill_grant got %b exp 1", bus.icache_grant); end
        issued = 0; got = 0; done = 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            bus.icache_MemRead = (issued < 8);
            bus.icache_mem_addr = 16'(issued * 2);
            #1;
            if (bus.mem_enable) begin
                checks++; if (bus.mem_addr !== 16'(issued * 2)) begin errors++; $display("FAIL fill_addr got %h exp %h", bus.mem_addr, 16'(issued * 2)); end
                issued++;
            end
            checks++; if (bus.dcache_MemDataValid !== 1'b0) begin errors++; $display("FAIL fill_dvalid got %b exp 0", bus.dcache_MemDataValid); end
            if (bus.icache_MemDataValid === 1'b1) begin
                checks++; if (bus.icache_mem_read_data !== 16'(got + 1)) begin errors++; $display("FAIL fill_data got %h exp %h", bus.icache_mem_read_data, 16'(got + 1)); end
                got++;
            end
            if (got == 8) done = 1;
            @(negedge clk);
        end
        #1;
        checks++; if (got !== 8) begin errors++; $display("FAIL fill_valid_count got %0d exp 8", got); end
        checks++; if (issued !== 8) begin errors++; $display("FAIL fill_issue_count got %0d exp 8", issued); end
        checks++; if (bus.icache_grant !== 1'b0) begin errors++; $display("FAIL fill_idle got %b exp 0", bus.icache_grant); end
    endtask

    task automatic test_tie();
        int seen;
        do_reset();
        model_on = 1'b1;
        bus.icache_MemRead = 1'b1; bus.icache_mem_addr = 16'h0100;
        bus.dcache_MemRead = 1'b1; bus.dcache_mem_addr = 16'h0200;
        @(negedge clk); #1;
        checks++; if (bus.dcache_grant !== 1'b1) begin errors++; $display("FAIL tie1_dgrant got %b exp 1", bus.dcache_grant); end
        checks++; if (bus.icache_grant !== 1'b0) begin errors++; $display("FAIL tie1_igrant got %b exp 0", bus.icache_grant); end
        checks++; if (bus.mem_addr !== 16'h0200) begin errors++; $display("FAIL tie1_addr got %h exp 0200", bus.mem_addr); end
        @(negedge clk);
        bus.icache_MemRead = 1'b0; bus.dcache_MemRead = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.dcache_grant !== 1'b1) break;
            checks++; if (bus.icache_MemDataValid !== 1'b0) begin errors++; $display("FAIL tie1_ivalid got %b exp 0", bus.icache_MemDataValid); end
            if (bus.dcache_MemDataValid === 1'b1) begin
                checks++; if (bus.dcache_mem_read_data !== 16'h0001) begin errors++; $display("FAIL tie1_ddata got %h exp 0001", bus.dcache_mem_read_data); end
                seen++;
            end
            @(negedge clk);
        end
        checks++; if (seen !== 1) begin errors++; $display("FAIL tie1_dvalid_count got %0d exp 1", seen); end
        checks++; if (bus.dcache_grant !== 1'b0) begin errors++; $display("FAIL tie1_release got %b exp 0", bus.dcache_grant); end
        bus.icache_MemRead = 1'b1; bus.dcache_MemRead = 1'b1;
        @(negedge clk); #1;
        checks++; if (bus.icache_grant !== 1'b1) begin errors++; $display("FAIL tie2_igrant got %b exp 1", bus.icache_grant); end
        checks++; if (bus.dcache_grant !== 1'b0) begin errors++; $display("FAIL tie2_dgrant got %b exp 0", bus.dcache_grant); end
        @(negedge clk);
        bus.icache_MemRead = 1'b0; bus.dcache_MemRead = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.icache_grant !== 1'b1) break;
            @(negedge clk);
        end
        checks++; if (bus.icache_grant !== 1'b0) begin errors++; $display("FAIL tie2_release got %b exp 0", bus.icache_grant); end
    endtask

    task automatic test_d_write();
        do_reset();
        bus.dcache_MemWrite = 1'b1;
        bus.dcache_mem_addr = 16'h0010;
        bus.dcache_mem_write_data = 16'hBEEF;
        @(negedge clk); #1;
        checks++; if (bus.dcache_grant !== 1'b1) begin errors++; $display("FAIL wr_grant got %b exp 1", bus.dcache_grant); end
        checks++; if (bus.mem_enable !== 1'b1) begin errors++; $display("FAIL wr_enable got %b exp 1", bus.mem_enable); end
        checks++; if (bus.mem_wr !== 1'b1) begin errors++; $display("FAIL wr_wr got %b exp 1", bus.mem_wr); end
        checks++; if (bus.mem_addr !== 16'h0010) begin errors++; $display("FAIL wr_addr got %h exp 0010", bus.mem_addr); end
        checks++; if (bus.mem_data_in !== 16'hBEEF) begin errors++; $display("FAIL wr_data got %h exp beef", bus.mem_data_in); end
        @(negedge clk);
        bus.dcache_MemWrite = 1'b0;
        #1;
        checks++; if (dut.outstanding !== 3'd0) begin errors++; $display("FAIL wr_ctr got %0d exp 0", dut.outstanding); end
        checks++; if (bus.mem_enable !== 1'b0) begin errors++; $display("FAIL wr_enable_off got %b exp 0", bus.mem_enable); end
        @(negedge clk); #1;
        checks++; if (bus.dcache_grant !== 1'b0) begin errors++; $display("FAIL wr_idle got %b exp 0", bus.dcache_grant); end
    endtask

    task automatic test_read_write();
        do_reset();
        bus.dcache_MemRead = 1'b1;
        bus.dcache_MemWrite = 1'b1;
        bus.dcache_mem_addr = 16'h0020;
        bus.dcache_mem_write_data = 16'h5555;
        @(negedge clk); #1;
        checks++; if (bus.mem_wr !== 1'b1) begin errors++; $display("FAIL rw_wr got %b exp 1", bus.mem_wr); end
        checks++; if (bus.mem_enable !== 1'b1) begin errors++; $display("FAIL rw_enable got %b exp 1", bus.mem_enable); end
        @(negedge clk);
        bus.dcache_MemRead = 1'b0;
        bus.dcache_MemWrite = 1'b0;
        man_valid = 1'b1;
        man_data = 16'h7777;
        #1;
        checks++; if (dut.outstanding !== 3'd0) begin errors++; $display("FAIL rw_ctr got %0d exp 0", dut.outstanding); end
        checks++; if (bus.dcache_MemDataValid !== 1'b0) begin errors++; $display("FAIL rw_stale_valid got %b exp 0", bus.dcache_MemDataValid); end
        checks++; if (bus.dcache_mem_read_data !== 16'h0) begin errors++; $display("FAIL rw_stale_data got %h exp 0000", bus.dcache_mem_read_data); end
        @(negedge clk);
        man_valid = 1'b0;
        #1;
        checks++; if (bus.dcache_grant !== 1'b0) begin errors++; $display("FAIL rw_idle got %b exp 0", bus.dcache_grant); end
        checks++; if (dut.outstanding !== 3'd0) begin errors++; $display("FAIL rw_ctr_after got %0d exp 0", dut.outstanding); end
    endtask

    task automatic test_reset_mid_fill();
        do_reset();
        bus.icache_MemRead = 1'b1;
        bus.icache_mem_addr = 16'h0040;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (dut.outstanding !== 3'd3) begin errors++; $display("FAIL rmf_ctr got %0d exp 3", dut.outstanding); end
        rst = 1'b1;
        bus.icache_MemRead = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.icache_grant !== 1'b0) begin errors++; $display("FAIL rmf_igrant got %b exp 0", bus.icache_grant); end
        checks++; if (bus.mem_enable !== 1'b0) begin errors++; $display("FAIL rmf_enable got %b exp 0", bus.mem_enable); end
        checks++; if (bus.mem_addr !== 16'h0) begin errors++; $display("FAIL rmf_addr got %h exp 0000", bus.mem_addr); end
        checks++; if (dut.outstanding !== 3'd0) begin errors++; $display("FAIL rmf_ctr_reset got %0d exp 0", dut.outstanding); end
        for (int k = 0; k < 3; k++) begin
            man_valid = 1'b1;
            man_data = 16'h1234;
            #1;
            checks++; if (bus.icache_MemDataValid !== 1'b0) begin errors++; $display("FAIL rmf_late_valid got %b exp 0", bus.icache_MemDataValid); end
            checks++; if (bus.icache_mem_read_data !== 16'h0) begin errors++; $display("FAIL rmf_late_data got %h exp 0000", bus.icache_mem_read_data); end
            @(negedge clk);
        end
        man_valid = 1'b0;
        #1;
        checks++; if (dut.outstanding !== 3'd0) begin errors++; $display("FAIL rmf_ctr_hold got %0d exp 0", dut.outstanding); end
    endtask

    task automatic test_saturation();
        do_reset();
        bus.dcache_MemRead = 1'b1;
        bus.dcache_mem_addr = 16'h0080;
        repeat (5) @(negedge clk);
        #1;
        checks++; if (dut.outstanding !== 3'd4) begin errors++; $display("FAIL sat_ctr got %0d exp 4", dut.outstanding); end
        checks++; if (bus.mem_enable !== 1'b0) begin errors++; $display("FAIL sat_stall got %b exp 0", bus.mem_enable); end
        @(negedge clk); #1;
        checks++; if (bus.mem_enable !== 1'b0) begin errors++; $display("FAIL sat_stall2 got %b exp 0", bus.mem_enable); end
        man_valid = 1'b1;
        man_data = 16'hAAAA;
        #1;
        checks++; if (bus.mem_enable !== 1'b1) begin errors++; $display("FAIL sat_release got %b exp 1", bus.mem_enable); end
        checks++; if (bus.dcache_MemDataValid !== 1'b1) begin errors++; $display("FAIL sat_dvalid got %b exp 1", bus.dcache_MemDataValid); end
        checks++; if (bus.dcache_mem_read_data !== 16'hAAAA) begin errors++; $display("FAIL sat_ddata got %h exp aaaa", bus.dcache_mem_read_data); end
        @(negedge clk);
        man_valid = 1'b0;
        #1;
        checks++; if (dut.outstanding !== 3'd4) begin errors++; $display("FAIL sat_ctr_after got %0d exp 4", dut.outstanding); end
        checks++; if (bus.mem_enable !== 1'b0) begin errors++; $display("FAIL sat_stall3 got %b exp 0", bus.mem_enable); end
        bus.dcache_MemRead = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            man_valid = 1'b1;
            man_data = 16'(k);
            #1;
            checks++; if (bus.dcache_MemDataValid !== 1'b1) begin errors++; $display("FAIL sat_drain_valid got %b exp 1", bus.dcache_MemDataValid); end
        end
        @(negedge clk);
        man_valid = 1'b0;
        #1;
        checks++; if (bus.dcache_grant !== 1'b0) begin errors++; $display("FAIL sat_idle got %b exp 0", bus.dcache_grant); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        model_on = 1'b0;
        man_valid = 1'b0;
        man_data = 16'h0;
        test_reset();
        test_i_fill();
        test_tie();
        test_d_write();
        test_read_write();
        test_reset_mid_fill();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have exactly one clock, clk, and one reset, rst; rst SHALL be synchronous and active-high.
REQ-002 clk  in  1  system clock, all state updates on posedge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 icache_MemRead  in  1  I-cache miss read request (cache_MemRead of I-cache).
REQ-005 icache_mem_addr  in  16  I-cache memory address.
REQ-006 dcache_MemRead  in  1  D-cache miss read request.
REQ-007 dcache_MemWrite  in  1  D-cache write-through request.
REQ-008 dcache_mem_addr  in  16  D-cache memory address.
REQ-009 dcache_mem_write_data  in  16  D-cache write data.
REQ-010 mem_data_out  in  16  read data from 4-cycle memory.
REQ-011 mem_data_valid  in  1  memory read data valid.
REQ-012 mem_enable  out  1  memory access strobe.
REQ-013 mem_wr  out  1  1 = write, 0 = read.
REQ-014 mem_addr  out  16  memory address.
REQ-015 mem_data_in  out  16  memory write data.
REQ-016 icache_MemDataValid / icache_mem_read_data  out  1 / 16  valid and data returned to I-cache.
REQ-017 dcache_MemDataValid / dcache_mem_read_data  out  1 / 16  valid and data returned to D-cache.
REQ-018 icache_grant / dcache_grant  out  1 / 1  current memory owner; never both 1.

Function
REQ-019 FSM states SHALL be IDLE, GRANT_I, GRANT_D.
REQ-020 IDLE: no grant; mem_enable=0; on any request, the registered transition to GRANT_x occurs next cycle (1-cycle arbitration latency).
REQ-021 D request = dcache_MemRead | dcache_MemWrite; I request = icache_MemRead.
REQ-022 Simultaneous I and D requests in IDLE: grant the requester not served last (round-robin); last_owner resets to I, so D wins the first tie.
REQ-023 GRANT_x: memory outputs SHALL mirror the owner's request combinationally; mem_enable = owner request.
REQ-024 GRANT_D with dcache_MemRead and dcache_MemWrite both 1: write SHALL win (mem_wr=1); the read is not issued that cycle.
REQ-025 Non-owner requests SHALL be held off (no memory access, no valid) until granted.
REQ-026 Outstanding counter (3 bits, 0..4): +1 on an issued read (mem_enable & ~mem_wr), -1 on mem_data_valid, unchanged when both occur in the same cycle.
REQ-027 GRANT_x -> IDLE when owner request is 0 and outstanding = 0 (including the same-cycle decrement to 0); last_owner updated on exit.
REQ-028 mem_data_valid and mem_data_out SHALL be routed combinationally to the owner only; the non-owner's valid = 0 and data = 0.
REQ-029 mem_data_valid when outstanding = 0, or in IDLE, SHALL be dropped: not forwarded, counter held at 0 (no underflow).
REQ-030 Counter SHALL saturate at 4; a 5th issue attempt SHALL be stalled (mem_enable=0) until a valid returns.
REQ-031 Writes SHALL not affect the counter and SHALL produce no valid.

Reset
REQ-032 On rst: state=IDLE, counter=0, last_owner=I; all outputs 0 the following cycle, including when reset occurs mid-grant; in-flight memory returns after reset are dropped per REQ-029.

Structure
REQ-033 Package mem_arb_pkg SHALL hold the state enum, ADDR_W=16, DATA_W=16, MEM_LAT=4, MAX_OUTSTANDING=4.
REQ-034 The outstanding counter SHALL be a sub-module named mem_outstanding_ctr; all other logic is flat.

Verification
REQ-035 I-only fill: icache_MemRead=1 at addr 0x0000..0x000E for 8 cycles, memory returns 1..8 -> icache_grant one cycle after request, icache_MemDataValid with data 1..8, dcache_MemDataValid stays 0, IDLE after the 8th valid.
REQ-036 Tie after reset: both request at the same cycle -> dcache_grant first; after D finishes, the next tie -> icache_grant.
REQ-037 D write: dcache_MemWrite=1, addr 0x0010, data 0xBEEF, 1 cycle -> mem_enable=1, mem_wr=1, mem_addr=0x0010, mem_data_in=0xBEEF; counter stays 0; IDLE the next cycle.
REQ-038 Read and write together: dcache_MemRead=dcache_MemWrite=1 -> mem_wr=1; counter unchanged.
REQ-039 Reset mid-fill: rst asserted after 3 reads are issued -> all outputs 0 the next cycle; late mem_data_valid pulses are not forwarded.
REQ-040 Saturation: 5 back-to-back reads with no valid -> 4 issued, 5th stalled with mem_enable=0; issued once the 1st valid arrives.
